// File: rtl/noc_bridge_pkg.sv
// Shared constants and helpers for the credit <-> valid/ready NoC bridge.
package noc_bridge_pkg;

    localparam int DEF_DATA_WIDTH   = 64;
    localparam int DEF_NUM_CHANNELS = 3;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_CREDITS      = 4;

    // The counter must hold every value from 0 up to and including the credit limit.
    function automatic int calc_cw(input int credits);
        return $clog2(credits + 1);
    endfunction

    typedef logic [DEF_DATA_WIDTH-1:0] default_flit_t;

endpackage

// File: rtl/noc_bridge_fifo.sv
// Per-channel receive FIFO. A push is taken while full only when a pop happens in
// the same cycle; otherwise the flit is dropped and the contents stay untouched.
module noc_bridge_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    // Equal indices: the wrap bit tells an empty buffer apart from a full one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/noc_credit_valrdy_bridge.sv
// Multi-channel bridge between credit-based (valid/yummy) NoC links and valid/ready
// interfaces; each channel converts in both directions independently.
module noc_credit_valrdy_bridge
    import noc_bridge_pkg::*;
#(
    parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter  int DEPTH        = DEF_DEPTH,
    parameter  int CREDITS      = DEF_CREDITS,
    localparam int CW           = calc_cw(CREDITS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CHANNELS-1:0]            cr_in_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] cr_in_data,
    output logic [NUM_CHANNELS-1:0]            cr_in_yummy,
    output logic [NUM_CHANNELS-1:0]            vr_out_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] vr_out_data,
    input  logic [NUM_CHANNELS-1:0]            vr_out_ready,
    input  logic [NUM_CHANNELS-1:0]            vr_in_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] vr_in_data,
    output logic [NUM_CHANNELS-1:0]            vr_in_ready,
    output logic [NUM_CHANNELS-1:0]            cr_out_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] cr_out_data,
    input  logic [NUM_CHANNELS-1:0]            cr_out_yummy,
    output logic [NUM_CHANNELS*CW-1:0]         credits_avail,
    output logic [NUM_CHANNELS-1:0]            ovf_err,
    output logic [NUM_CHANNELS-1:0]            crd_err
);

    typedef logic [DATA_WIDTH-1:0] flit_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : gen_ch
        flit_t          head;
        flit_t          out_data_q;
        logic           fifo_full;
        logic           fifo_empty;
        logic           pop;
        logic           drop;
        logic           fire;
        logic           yummy_q;
        logic           out_valid_q;
        logic           ovf_q;
        logic           crd_q;
        logic [CW-1:0]  credits;

        // Credit -> valid/ready direction.
        noc_bridge_fifo #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (cr_in_valid[c]),
            .push_data (cr_in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .pop       (pop),
            .head_data (head),
            .full      (fifo_full),
            .empty     (fifo_empty)
        );

        assign pop  = !fifo_empty && vr_out_ready[c];
        assign drop = cr_in_valid[c] && fifo_full && !pop;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                yummy_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                yummy_q <= pop;
                if (drop) ovf_q <= 1'b1;
            end
        end

        // Valid/ready -> credit direction; ready comes only from the credit register.
        assign fire = vr_in_valid[c] && (credits != '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                credits <= CRED_MAX;
                crd_q   <= 1'b0;
            end else begin
                unique case ({fire, cr_out_yummy[c]})
                    2'b10: credits <= credits - 1'b1;
                    2'b01: begin
                        if (credits == CRED_MAX) crd_q   <= 1'b1;
                        else                     credits <= credits + 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= fire;
                if (fire) out_data_q <= vr_in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        assign cr_in_yummy[c]                          = yummy_q;
        assign vr_out_valid[c]                         = !fifo_empty;
        assign vr_out_data[c*DATA_WIDTH +: DATA_WIDTH] = head;
        assign vr_in_ready[c]                          = (credits != '0);
        assign cr_out_valid[c]                         = out_valid_q;
        assign cr_out_data[c*DATA_WIDTH +: DATA_WIDTH] = out_data_q;
        assign credits_avail[c*CW +: CW]               = credits;
        assign ovf_err[c]                              = ovf_q;
        assign crd_err[c]                              = crd_q;
    end

endmodule

// File: tb/tb_noc_credit_valrdy_bridge.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_noc_credit_valrdy_bridge;

    localparam int DW      = 64;
    localparam int NC      = 3;
    localparam int DEPTH   = 4;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic              clk;
    logic              rst_n;
    logic [NC-1:0]     cr_in_valid;
    logic [NC*DW-1:0]  cr_in_data;
    logic [NC-1:0]     cr_in_yummy;
    logic [NC-1:0]     vr_out_valid;
    logic [NC*DW-1:0]  vr_out_data;
    logic [NC-1:0]     vr_out_ready;
    logic [NC-1:0]     vr_in_valid;
    logic [NC*DW-1:0]  vr_in_data;
    logic [NC-1:0]     vr_in_ready;
    logic [NC-1:0]     cr_out_valid;
    logic [NC*DW-1:0]  cr_out_data;
    logic [NC-1:0]     cr_out_yummy;
    logic [NC*CW-1:0]  credits_avail;
    logic [NC-1:0]     ovf_err;
    logic [NC-1:0]     crd_err;

    int tests_run = 0;
    int tests_failed = 0;

    noc_credit_valrdy_bridge #(
        .DATA_WIDTH   (DW),
        .NUM_CHANNELS (NC),
        .DEPTH        (DEPTH),
        .CREDITS      (CREDITS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cr_in_valid   (cr_in_valid),
        .cr_in_data    (cr_in_data),
        .cr_in_yummy   (cr_in_yummy),
        .vr_out_valid  (vr_out_valid),
        .vr_out_data   (vr_out_data),
        .vr_out_ready  (vr_out_ready),
        .vr_in_valid   (vr_in_valid),
        .vr_in_data    (vr_in_data),
        .vr_in_ready   (vr_in_ready),
        .cr_out_valid  (cr_out_valid),
        .cr_out_data   (cr_out_data),
        .cr_out_yummy  (cr_out_yummy),
        .credits_avail (credits_avail),
        .ovf_err       (ovf_err),
        .crd_err       (crd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model state for the randomized test.
    typedef logic [DW-1:0] flit_q_t [$];
    flit_q_t       mq [NC];
    int            m_cred [NC];
    logic [NC-1:0] m_yum, m_ovf, m_crd, m_cov;
    logic [DW-1:0] m_cod [NC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cr_in_valid  = '0;
        cr_in_data   = '0;
        vr_out_ready = '0;
        vr_in_valid  = '0;
        vr_in_data   = '0;
        cr_out_yummy = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [DW-1:0] flit_of(input logic [NC*DW-1:0] bus, input int c);
        return bus[c*DW +: DW];
    endfunction

    function automatic int cred_of(input int c);
        return int'(credits_avail[c*CW +: CW]);
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < NC; c++) begin
            tests_run++;
            if (cred_of(c) !== CREDITS) begin
                tests_failed++;
                $display("FAIL reset_credits ch%0d: got %0d expected %0d", c, cred_of(c), CREDITS);
            end
        end
        tests_run++;
        if (vr_in_ready !== '1) begin
            tests_failed++;
            $display("FAIL reset_vr_in_ready: got %b expected all ones", vr_in_ready);
        end
        tests_run++;
        if ({vr_out_valid, cr_out_valid, cr_in_yummy, ovf_err, crd_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected zero",
                     {vr_out_valid, cr_out_valid, cr_in_yummy, ovf_err, crd_err});
        end
        tests_run++;
        if ({vr_out_data, cr_out_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got nonzero output data, expected zero");
        end
    endtask

    task automatic test_stream();
        logic exp_yum [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        clear_inputs();
        vr_out_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cr_in_valid[0] = (i < 4);
            cr_in_data[0*DW +: DW] = 64'hA0 + 64'(i);
            tick();
            if (i < 4) begin
                tests_run++;
                if (vr_out_valid[0] !== 1'b1 || flit_of(vr_out_data, 0) !== 64'hA0 + 64'(i)) begin
                    tests_failed++;
                    $display("FAIL stream_data[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                             i, vr_out_valid[0], flit_of(vr_out_data, 0), 64'hA0 + 64'(i));
                end
            end
            tests_run++;
            if (cr_in_yummy[0] !== exp_yum[i]) begin
                tests_failed++;
                $display("FAIL stream_yummy[%0d]: got %b expected %b", i, cr_in_yummy[0], exp_yum[i]);
            end
        end
        tests_run++;
        if (vr_out_valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_drained: got valid=%b expected 0", vr_out_valid[0]);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        int y = 0;
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            cr_in_valid[1] = 1'b1;
            cr_in_data[1*DW +: DW] = 64'hB0 + 64'(i);
            tick();
            if (i == 3) begin
                tests_run++;
                if (ovf_err[1] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ovf_early: got %b expected 0", ovf_err[1]);
                end
            end
        end
        tests_run++;
        if (ovf_err[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set: got %b expected 1", ovf_err[1]);
        end
        tests_run++;
        if (cr_in_yummy[1] !== 1'b0 || flit_of(vr_out_data, 1) !== 64'hB0) begin
            tests_failed++;
            $display("FAIL ovf_hold: got yummy=%b head=%h expected yummy=0 head=b0",
                     cr_in_yummy[1], flit_of(vr_out_data, 1));
        end
        cr_in_valid[1]  = 1'b0;
        vr_out_ready[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (vr_out_valid[1]) begin
                tests_run++;
                if (flit_of(vr_out_data, 1) !== 64'hB0 + 64'(n)) begin
                    tests_failed++;
                    $display("FAIL ovf_drain_data[%0d]: got %h expected %h",
                             n, flit_of(vr_out_data, 1), 64'hB0 + 64'(n));
                end
                n++;
            end
            tick();
            if (cr_in_yummy[1]) y++;
        end
        tests_run++;
        if (n !== 4 || y !== 4) begin
            tests_failed++;
            $display("FAIL ovf_drain_count: got flits=%0d yummies=%0d expected 4 and 4", n, y);
        end
        tests_run++;
        if (ovf_err[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf_err[1]);
        end
    endtask

    task automatic test_credit_exhaust();
        int hs_cnt = 0;
        logic hs;
        clear_inputs();
        vr_in_valid[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vr_in_data[2*DW +: DW] = 64'hC0 + 64'(i);
            hs = vr_in_ready[2];
            tick();
            if (hs) hs_cnt++;
            tests_run++;
            if (cr_out_valid[2] !== hs || (hs && flit_of(cr_out_data, 2) !== 64'hC0 + 64'(i))) begin
                tests_failed++;
                $display("FAIL exhaust_out[%0d]: got valid=%b data=%h expected valid=%b data=%h",
                         i, cr_out_valid[2], flit_of(cr_out_data, 2), hs, 64'hC0 + 64'(i));
            end
        end
        tests_run++;
        if (hs_cnt !== 4 || vr_in_ready[2] !== 1'b0 || cred_of(2) !== 0) begin
            tests_failed++;
            $display("FAIL exhaust_state: got hs=%0d ready=%b credits=%0d expected 4, 0, 0",
                     hs_cnt, vr_in_ready[2], cred_of(2));
        end
        cr_out_yummy[2] = 1'b1;
        tick();
        cr_out_yummy[2] = 1'b0;
        tests_run++;
        if (vr_in_ready[2] !== 1'b1 || cr_out_valid[2] !== 1'b0 || cred_of(2) !== 1) begin
            tests_failed++;
            $display("FAIL exhaust_yummy: got ready=%b valid=%b credits=%0d expected 1, 0, 1",
                     vr_in_ready[2], cr_out_valid[2], cred_of(2));
        end
        vr_in_data[2*DW +: DW] = 64'hC9;
        tick();
        vr_in_valid[2] = 1'b0;
        tests_run++;
        if (cr_out_valid[2] !== 1'b1 || flit_of(cr_out_data, 2) !== 64'hC9 || cred_of(2) !== 0) begin
            tests_failed++;
            $display("FAIL exhaust_resend: got valid=%b data=%h credits=%0d expected 1, c9, 0",
                     cr_out_valid[2], flit_of(cr_out_data, 2), cred_of(2));
        end
    endtask

    task automatic test_fire_yummy();
        clear_inputs();
        cr_out_yummy[2] = 1'b1;
        tick();
        tick();
        tests_run++;
        if (cred_of(2) !== 2) begin
            tests_failed++;
            $display("FAIL fy_refill: got %0d expected 2", cred_of(2));
        end
        vr_in_valid[2] = 1'b1;
        vr_in_data[2*DW +: DW] = 64'hD0;
        tick();
        vr_in_valid[2] = 1'b0;
        tests_run++;
        if (cred_of(2) !== 2 || cr_out_valid[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL fy_simultaneous: got credits=%0d valid=%b expected 2, 1", cred_of(2), cr_out_valid[2]);
        end
        tick();
        tick();
        tests_run++;
        if (cred_of(2) !== 4 || crd_err[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL fy_full: got credits=%0d crd_err=%b expected 4, 0", cred_of(2), crd_err[2]);
        end
        tick();
        cr_out_yummy[2] = 1'b0;
        tests_run++;
        if (cred_of(2) !== 4 || crd_err[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL fy_saturate: got credits=%0d crd_err=%b expected 4, 1", cred_of(2), crd_err[2]);
        end
    endtask

    task automatic test_random();
        logic pop, full, fire;
        do_reset();
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            m_cred[c] = CREDITS;
            m_cod[c]  = '0;
        end
        m_yum = '0; m_ovf = '0; m_crd = '0; m_cov = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                cr_in_valid[c]  = ($urandom_range(0, 1) == 1);
                cr_in_data[c*DW +: DW] = {$urandom, $urandom};
                vr_out_ready[c] = ($urandom_range(0, 3) != 0);
                vr_in_valid[c]  = ($urandom_range(0, 1) == 1);
                vr_in_data[c*DW +: DW] = {$urandom, $urandom};
                cr_out_yummy[c] = ($urandom_range(0, 4) == 0);
            end
            for (int c = 0; c < NC; c++) begin
                pop  = (mq[c].size() > 0) && vr_out_ready[c];
                full = (mq[c].size() == DEPTH);
                if (pop) void'(mq[c].pop_front());
                if (cr_in_valid[c]) begin
                    if (full && !pop) m_ovf[c] = 1'b1;
                    else mq[c].push_back(flit_of(cr_in_data, c));
                end
                m_yum[c] = pop;
                fire = vr_in_valid[c] && (m_cred[c] > 0);
                m_cov[c] = fire;
                if (fire) m_cod[c] = flit_of(vr_in_data, c);
                m_cred[c] = m_cred[c] - int'(fire) + int'(cr_out_yummy[c]);
                if (m_cred[c] > CREDITS) begin
                    m_cred[c] = CREDITS;
                    m_crd[c]  = 1'b1;
                end
            end
            tick();
            for (int c = 0; c < NC; c++) begin
                tests_run++;
                if (vr_out_valid[c] !== (mq[c].size() > 0) ||
                    (mq[c].size() > 0 && flit_of(vr_out_data, c) !== mq[c][0])) begin
                    tests_failed++;
                    $display("FAIL rand_vr_out cyc%0d ch%0d: got valid=%b data=%h expected occupancy=%0d",
                             cyc, c, vr_out_valid[c], flit_of(vr_out_data, c), mq[c].size());
                end
                tests_run++;
                if (cr_in_yummy[c] !== m_yum[c]) begin
                    tests_failed++;
                    $display("FAIL rand_yummy cyc%0d ch%0d: got %b expected %b", cyc, c, cr_in_yummy[c], m_yum[c]);
                end
                tests_run++;
                if (cred_of(c) !== m_cred[c] || vr_in_ready[c] !== (m_cred[c] > 0)) begin
                    tests_failed++;
                    $display("FAIL rand_credits cyc%0d ch%0d: got %0d ready=%b expected %0d",
                             cyc, c, cred_of(c), vr_in_ready[c], m_cred[c]);
                end
                tests_run++;
                if (cr_out_valid[c] !== m_cov[c] || (m_cov[c] && flit_of(cr_out_data, c) !== m_cod[c])) begin
                    tests_failed++;
                    $display("FAIL rand_cr_out cyc%0d ch%0d: got valid=%b data=%h expected valid=%b data=%h",
                             cyc, c, cr_out_valid[c], flit_of(cr_out_data, c), m_cov[c], m_cod[c]);
                end
                tests_run++;
                if (ovf_err[c] !== m_ovf[c] || crd_err[c] !== m_crd[c]) begin
                    tests_failed++;
                    $display("FAIL rand_errs cyc%0d ch%0d: got ovf=%b crd=%b expected ovf=%b crd=%b",
                             cyc, c, ovf_err[c], crd_err[c], m_ovf[c], m_crd[c]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        vr_out_ready[2] = 1'b1;
        vr_in_valid[1]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cr_in_valid[0] = 1'b1;
            cr_in_data[0*DW +: DW] = 64'hE0 + 64'(i);
            cr_in_valid[2] = (i == 1);
            cr_in_data[2*DW +: DW] = 64'hF0;
            vr_in_data[1*DW +: DW] = 64'hE8 + 64'(i);
            tick();
        end
        tests_run++;
        if (vr_out_valid[0] !== 1'b1 || cred_of(1) !== 1 || cr_in_yummy[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_setup: got valid0=%b credits1=%0d yummy2=%b expected 1, 1, 1",
                     vr_out_valid[0], cred_of(1), cr_in_yummy[2]);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({vr_out_valid, cr_out_valid, cr_in_yummy, ovf_err, crd_err} !== '0 ||
            {vr_out_data, cr_out_data} !== '0) begin
            tests_failed++;
            $display("FAIL midrst_async: got flags=%b expected zero",
                     {vr_out_valid, cr_out_valid, cr_in_yummy, ovf_err, crd_err});
        end
        for (int c = 0; c < NC; c++) begin
            tests_run++;
            if (cred_of(c) !== CREDITS || vr_in_ready[c] !== 1'b1) begin
                tests_failed++;
                $display("FAIL midrst_credits ch%0d: got %0d expected %0d", c, cred_of(c), CREDITS);
            end
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        vr_out_ready = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (cr_in_yummy !== '0 || vr_out_valid !== '0 || cred_of(1) !== CREDITS) begin
                tests_failed++;
                $display("FAIL midrst_release[%0d]: got yummy=%b valid=%b credits1=%0d expected 0, 0, %0d",
                         i, cr_in_yummy, vr_out_valid, cred_of(1), CREDITS);
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_stream();
        test_overflow();
        test_credit_exhaust();
        test_fire_yummy();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/noc_credit_valrdy_bridge.md
# noc_credit_valrdy_bridge

Parametrised, multi-channel bridge between credit-based (valid/yummy) NoC links and valid/ready interfaces. It supersedes the fixed single-channel, fixed-width credit-to-valrdy and valrdy-to-credit converter pair. It sits between the chip's NoC ports (noc1/noc2/noc3) and off-chip valid/ready consumers such as the AXI4 bridge. Each channel converts in both directions and provides buffer depth, credit count and error flags.

## Interface
- DATA_WIDTH, 64: flit width.
- NUM_CHANNELS, 3: number of independent channels.
- DEPTH, 4: per-channel receive FIFO depth. Power of two, ≥2. Also the number of credits the upstream sender must hold.
- CREDITS, 4: credits held toward the downstream credit receiver; counter width CW = $clog2(CREDITS+1).
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- cr_in_valid  in  NUM_CHANNELS  credit-side inbound flit valid.
- cr_in_data  in  NUM_CHANNELS*DATA_WIDTH  inbound flits, channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- cr_in_yummy  out  NUM_CHANNELS  one-cycle credit return to the upstream sender.
- vr_out_valid  out  NUM_CHANNELS  valid/ready outbound valid.
- vr_out_data  out  NUM_CHANNELS*DATA_WIDTH  outbound data.
- vr_out_ready  in  NUM_CHANNELS  consumer ready.
- vr_in_valid  in  NUM_CHANNELS  valid/ready inbound valid.
- vr_in_data  in  NUM_CHANNELS*DATA_WIDTH  inbound data.
- vr_in_ready  out  NUM_CHANNELS  high when a credit is available.
- cr_out_valid  out  NUM_CHANNELS  credit-side outbound flit valid.
- cr_out_data  out  NUM_CHANNELS*DATA_WIDTH  outbound flits.
- cr_out_yummy  in  NUM_CHANNELS  credit returned by the downstream receiver.
- credits_avail  out  NUM_CHANNELS*CW  current credit count per channel.
- ovf_err  out  NUM_CHANNELS  sticky: a flit was dropped because the FIFO was full.
- crd_err  out  NUM_CHANNELS  sticky: a yummy arrived while the credit count was already CREDITS.

## Operation
- Channels are fully independent; no arbitration between them.
- **Credit→valrdy path, per channel:**
  - A flit with cr_in_valid=1 is pushed into the FIFO.
  - vr_out_valid = FIFO not empty; vr_out_data = FIFO head.
  - A pop occurs on vr_out_valid & vr_out_ready.
  - Each pop produces exactly one registered cr_in_yummy pulse in the next cycle.
- **Push while full:**
  - With a simultaneous pop: the push is accepted, occupancy is unchanged, no error.
  - Without a pop: the flit is dropped, ovf_err sets, and the FIFO is unchanged.
- **Valrdy→credit path, per channel:**
  - vr_in_ready = (credits != 0), driven from the credit register (no combinational path from inputs).
  - A handshake (vr_in_valid & vr_in_ready) registers vr_in_data into cr_out_data and sets cr_out_valid for exactly one cycle.
  - The credit side has no backpressure.
- **Credit counter:** next = credits − fire + yummy.
  - fire and yummy in the same cycle: count unchanged.
  - yummy with credits==CREDITS and no fire: count stays at CREDITS (saturates) and crd_err sets.
- Sticky errors clear only on reset.
- **Reset (asynchronous):**
  - FIFOs emptied; credits = CREDITS.
  - vr_out_valid, cr_out_valid, cr_in_yummy, ovf_err and crd_err = 0.
  - cr_out_data and vr_out_data = 0.
  - Reset mid-transfer discards in-flight flits and pending yummies; no pulse is emitted after reset release until a new pop.

## Timing
- Credit→valrdy latency: push in cycle t gives vr_out_valid=1 with that data in cycle t+1. Push and pop are permitted in the same cycle.
- Yummy latency: a pop in cycle t gives cr_in_yummy=1 in cycle t+1. Back-to-back pops give a continuous yummy stream.
- Valrdy→credit latency: handshake in t gives cr_out_valid in t+1.
- Throughput: one flit per cycle per direction per channel when credits and FIFO space allow.
- A yummy received in t makes vr_in_ready high in t+1 if credits were 0.
- FIFO pointers are log2(DEPTH) bits plus one wrap bit; full/empty are derived from pointer compare and wrap correctly.

## Structure
- Package noc_bridge_pkg holds:
  - the default DATA_WIDTH, DEPTH and CREDITS constants;
  - a CW helper function;
  - a flit_t typedef parametrised via localparam in the module.
- Sub-module noc_bridge_fifo: synchronous FIFO with DEPTH and DATA_WIDTH parameters, push/pop/full/empty, and drop-on-full behaviour. It is instantiated once per channel in a generate loop.
- Credit counter and output registers are inline in the top generate loop.

## Test plan
- **Reset values:** after reset, every channel shows credits_avail=4, vr_in_ready=1, all valid/yummy/err outputs 0.
- **Credit→valrdy streaming:** channel 0 pushes 0xA0..0xA3 on consecutive cycles with vr_out_ready=1 → same data on vr_out_data at t+1..t+4, yummy high for 4 consecutive cycles starting at t+2.
- **Overflow:** vr_out_ready=0, push 5 flits on channel 1 → first 4 buffered, 5th dropped, ovf_err[1]=1. Then ready=1 → exactly 4 flits drained and 4 yummies.
- **Credit exhaustion:** channel 2 with vr_in_valid held high and no yummy → 4 handshakes, then vr_in_ready=0 and credits_avail=0. One yummy → ready=1 the next cycle and one more flit is sent.
- **Simultaneous fire and yummy:** at credits=2, fire and yummy in the same cycle → count stays 2. A yummy at credits=4 → count stays 4 and crd_err=1.
- **Mid-operation reset:** rst_n asserted with 3 flits buffered and credits=1 → outputs return to reset values immediately, no yummy after release, credits=4.
